// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation controller for a pad-connected SAR ADC.
// One conversion per start request: track phase, then one settle/decide slot
// per bit from MSB to LSB, then a single-cycle done pulse with the result.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int MAXC  = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int BI_W  = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [BI_W-1:0]  BI_ONE      = BI_W'(1);
    localparam logic [BI_W-1:0]  BI_TOP      = BI_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CODE_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] CODE_MSB    = CODE_ONE << (WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_SETTLE = 3'd2,
        S_DECIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BI_W-1:0]  bi_q, bi_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             sample_en_q, sample_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sync1_q, sync2_q;
    logic [WIDTH-1:0] decided_s;

    // Two-flop synchronizer for the asynchronous comparator decision.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= cmp_in;
            sync2_q <= sync1_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bi_q        <= '0;
            code_q      <= '0;
            result_q    <= '0;
            sample_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bi_q        <= bi_d;
            code_q      <= code_d;
            result_q    <= result_d;
            sample_en_q <= sample_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next state; output values are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bi_d        = bi_q;
        code_d      = code_q;
        result_d    = result_q;
        sample_en_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        // Trial bit is 1, so writing the comparator value clears or keeps it.
        decided_s        = code_q;
        decided_s[bi_q]  = sync2_q;

        case (state_q)
            S_IDLE: begin
                code_d = '0;
                cnt_d  = '0;
                if (start) begin
                    state_d     = S_SAMPLE;
                    busy_d      = 1'b1;
                    sample_en_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    code_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == SAMPLE_LAST) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                    bi_d    = BI_TOP;
                    code_d  = CODE_MSB;
                    busy_d  = 1'b1;
                end else begin
                    cnt_d       = cnt_q + CNT_ONE;
                    busy_d      = 1'b1;
                    sample_en_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    code_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_DECIDE;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                    busy_d = 1'b1;
                end
            end
            S_DECIDE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    code_d  = '0;
                    cnt_d   = '0;
                end else if (bi_q != '0) begin
                    state_d = S_SETTLE;
                    bi_d    = bi_q - BI_ONE;
                    code_d  = decided_s | (CODE_ONE << (bi_q - BI_ONE));
                    busy_d  = 1'b1;
                end else begin
                    state_d  = S_DONE;
                    code_d   = decided_s;
                    result_d = decided_s;
                    done_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                code_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                code_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign sample_en = sample_en_q;
    assign dac_code  = code_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl with an ideal comparator model.
module tb_sar_adc_ctrl;

    localparam int W       = 8;
    localparam int SC      = 4;
    localparam int ST      = 2;
    localparam int BIT_CYC = ST + 1;
    localparam int DONE_C  = 1 + SC + W * BIT_CYC;

    logic         clk;
    logic         nRst;
    logic         start;
    logic         abort;
    logic         cmp_in;
    logic         sample_en;
    logic [W-1:0] dac_code;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    logic [W-1:0] vin;
    logic         noise_en;
    logic         noise_val;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] vin;
        logic [W-1:0] exp_res;
    } vec_t;
    vec_t tbl[7];

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(ST)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .start     (start),
        .abort     (abort),
        .cmp_in    (cmp_in),
        .sample_en (sample_en),
        .dac_code  (dac_code),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    assign cmp_in = noise_en ? noise_val : (vin >= dac_code);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Binary search: trial code presented for step k (k=0 is the MSB).
    function automatic logic [W-1:0] model_trial(input logic [W-1:0] v, input int k);
        logic [W-1:0] acc;
        logic [W-1:0] t;
        acc = '0;
        for (int j = 0; j < k; j++) begin
            t = acc | (W'(1) << (W - 1 - j));
            if (v >= t) acc = t;
        end
        return acc | (W'(1) << (W - 1 - k));
    endfunction

    function automatic logic [W-1:0] model_result(input logic [W-1:0] v);
        logic [W-1:0] acc;
        logic [W-1:0] t;
        acc = '0;
        for (int j = 0; j < W; j++) begin
            t = acc | (W'(1) << (W - 1 - j));
            if (v >= t) acc = t;
        end
        return acc;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, " sample_en"}, int'(sample_en), 0);
        chk({tag, " dac_code"}, int'(dac_code), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
    endtask

    // One full conversion from an IDLE cycle (cycle 0); returns in cycle DONE_C+1.
    task automatic convert(input logic [W-1:0] v, input bit poke, input bit glitch, input bit abort0);
        logic         good;
        logic [W-1:0] exp_dac;
        vin   = v;
        start = 1'b1;
        abort = abort0;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= DONE_C; c++) begin
            if (c > 1) tick();
            start    = poke && (c == 10 || c == DONE_C);
            noise_en = 1'b0;
            if (c <= SC) exp_dac = '0;
            else if (c < DONE_C) exp_dac = model_trial(v, (c - SC - 1) / BIT_CYC);
            else exp_dac = model_result(v);
            chk($sformatf("busy v=%0h c%0d", v, c), int'(busy), int'(c < DONE_C));
            chk($sformatf("sample_en v=%0h c%0d", v, c), int'(sample_en), int'(c <= SC));
            chk($sformatf("done v=%0h c%0d", v, c), int'(done), int'(c == DONE_C));
            chk($sformatf("dac_code v=%0h c%0d", v, c), int'(dac_code), int'(exp_dac));
            if (c == DONE_C)
                chk($sformatf("result v=%0h", v), int'(result), int'(model_result(v)));
            // Garbage on the last settle cycle must never reach the decision.
            if (glitch && c > SC && c < DONE_C && ((c - SC - 1) % BIT_CYC) == ST - 1) begin
                good      = (v >= dac_code);
                noise_en  = 1'b1;
                noise_val = ~good;
                #2 noise_val = good;
                #2 noise_val = ~good;
                #1 noise_val = good;
                #1 noise_val = ~good;
            end
        end
        tick();
        start    = 1'b0;
        noise_en = 1'b0;
    endtask

    initial begin : main
        int           done_at[$];
        int           rise_at[$];
        logic         prevb;
        bit           seen_done;
        logic [W-1:0] rv;

        tbl[0] = '{8'hA5, 8'hA5};
        tbl[1] = '{8'hFF, 8'hFF};
        tbl[2] = '{8'h00, 8'h00};
        tbl[3] = '{8'h01, 8'h01};
        tbl[4] = '{8'h80, 8'h80};
        tbl[5] = '{8'h7F, 8'h7F};
        tbl[6] = '{8'h3C, 8'h3C};

        nRst      = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        vin       = '0;
        noise_en  = 1'b0;
        noise_val = 1'b0;
        #3;
        check_idle("reset");
        chk("reset result", int'(result), 0);
        #9 nRst = 1'b1;
        tick();
        check_idle("post-reset");

        // Table of known conversions, including both extremes.
        for (int i = 0; i < 7; i++) begin
            convert(tbl[i].vin, 1'b0, 1'b0, 1'b0);
            chk($sformatf("table[%0d] result", i), int'(result), int'(tbl[i].exp_res));
        end

        // Starts during a running conversion and during DONE are ignored.
        convert(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("poke c30 busy", int'(busy), 0);
        tick();
        chk("poke c31 busy", int'(busy), 0);
        chk("poke result", int'(result), 8'hA5);

        // start held high: back-to-back conversions re-arm after DONE.
        vin   = 8'h5A;
        start = 1'b1;
        prevb = 1'b0;
        for (int c = 1; c <= 62; c++) begin
            tick();
            if (busy && !prevb) rise_at.push_back(c);
            if (done) done_at.push_back(c);
            prevb = busy;
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("held abort busy", int'(busy), 0);
        chk("held done count", done_at.size(), 2);
        chk("held rise count", rise_at.size(), 3);
        if (done_at.size() == 2) begin
            chk("held done1 cycle", done_at[0], DONE_C);
            chk("held done2 cycle", done_at[1], 2 * DONE_C + 1);
        end
        if (rise_at.size() == 3) begin
            chk("held rise2 cycle", rise_at[1], DONE_C + 2);
            chk("held rise3 cycle", rise_at[2], 2 * DONE_C + 3);
        end
        chk("held result", int'(result), 8'h5A);
        tick();

        // Abort during a conversion leaves the previous result intact.
        convert(8'hA5, 1'b0, 1'b0, 1'b0);
        vin   = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort");
        seen_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("abort no done", int'(seen_done), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort result kept", int'(result), 8'hA5);
        // abort together with start in IDLE: start wins.
        convert(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("after abort result", int'(result), 8'h3C);

        // Random codes against the model, with random late-settle glitches.
        for (int i = 0; i < 12; i++) begin
            rv = W'($urandom_range(0, 255));
            convert(rv, 1'b0, ($urandom_range(0, 1) == 1), 1'b0);
        end
        convert(8'hC9, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of SETTLE.
        vin   = 8'hC3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 6; c++) tick();
        chk("pre-reset busy", int'(busy), 1);
        #3 nRst = 1'b0;
        #1;
        check_idle("async reset");
        chk("async reset result", int'(result), 0);
        #3 nRst = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check_idle($sformatf("idle after reset c%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Digital successive-approximation controller for an off-chip-referenced SAR ADC built around the c35 analog pad ring. It sits directly upstream of the analog I/O pads: `sample_en` and `dac_code` drive the track/hold switch and the capacitive DAC through analog pads, and it consumes the comparator decision that returns through an analog pad as `cmp_in`. It runs one conversion per `start` request and delivers a WIDTH-bit result with a one-cycle `done` pulse.

## Interface
- WIDTH, 8, resolution in bits (legal 2..16)
- SAMPLE_CYCLES, 4, track phase length in clocks (≥1)
- SETTLE_CYCLES, 2, DAC/comparator settle per bit in clocks (≥2, covers synchronizer)
- clk  input  1  system clock, all state on rising edge
- nRst  input  1  asynchronous active-low reset
- start  input  1  conversion request, sampled only in IDLE
- abort  input  1  synchronous cancel of a running conversion
- cmp_in  input  1  comparator output from pad, asynchronous; 1 = Vin ≥ Vdac
- sample_en  output  1  track/hold switch enable, registered
- dac_code  output  WIDTH  trial code to DAC, registered
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  last completed conversion, held until the next `done`

## Operation
- `cmp_in` passes a 2-flop synchronizer (`cmp_sync`), always clocked; only `cmp_sync` is used.
- States: IDLE, SAMPLE, SETTLE, DECIDE, DONE. Bit index `bi` counts WIDTH-1 down to 0; cycle counter `cnt` is wide enough for max(SAMPLE_CYCLES, SETTLE_CYCLES).
- IDLE: `dac_code`=0, `sample_en`=0, `busy`=0. `start`=1 → SAMPLE, `cnt` cleared.
- SAMPLE: `sample_en`=1, `busy`=1, `dac_code`=0. After SAMPLE_CYCLES cycles → SETTLE with `bi`=WIDTH-1; `dac_code` bit WIDTH-1 set on the same edge.
- SETTLE: `dac_code` = decided bits | trial bit `bi`; held SETTLE_CYCLES cycles → DECIDE.
- DECIDE (1 cycle): `cmp_sync`=0 → clear bit `bi`; `cmp_sync`=1 → keep it. If `bi`>0: `bi`-1, set new trial bit, → SETTLE. If `bi`=0: `result` ← final code (including this decision), → DONE.
- DONE (1 cycle): `done`=1, `busy`=0, `dac_code` holds final code; → IDLE (`dac_code`→0).
- `start` outside IDLE (including DONE) is ignored, not queued. `start` held high continuously re-arms in the IDLE cycle after DONE.
- `abort`=1 in SAMPLE/SETTLE/DECIDE → IDLE on next edge; no `done`; `result` unchanged. `abort` in IDLE/DONE has no effect. `abort` and `start` together in IDLE: `start` wins (abort is ignored in IDLE).
- `result` is written only in the final DECIDE.

## Timing
- Reset (nRst low, asynchronous, any state, mid-conversion included): state IDLE; `sample_en`=0, `dac_code`=0, `busy`=0, `done`=0, `result`=0, synchronizer flops 0, counters 0.
- `start` high in IDLE in cycle 0 → `busy`/`sample_en` high from cycle 1. `sample_en` stays high for cycles 1..SAMPLE_CYCLES.
- Each bit takes SETTLE_CYCLES+1 cycles. For bit `bi`, `dac_code` is valid from the first SETTLE cycle. DECIDE uses `cmp_sync`, which reflects `cmp_in` two edges earlier.
- `done` is high in cycle 1+SAMPLE_CYCLES+WIDTH·(SETTLE_CYCLES+1). With defaults this is cycle 29. `busy` is high for cycles 1..28, and `result` is valid from cycle 29.
- The next conversion starts at the earliest with `start` sampled in cycle 30 (IDLE), so `busy` goes high in cycle 31.

## Test plan
- Reset: drive nRst low mid-SETTLE → all outputs 0 immediately, without a clock edge. Release nRst, idle 5 cycles → outputs stay 0, `done` never pulses.
- Bench comparator model: `cmp_in` = (vin ≥ `dac_code`). With vin=0xA5, pulse `start` in cycle 0 → `sample_en` high in cycles 1-4, `done` high only in cycle 29, `result`=0xA5, `busy` high exactly in cycles 1-28. Trial sequence: 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
- Extremes: vin=0xFF → `result`=0xFF; vin=0x00 → `result`=0x00. Check dac_code trial 0x80 → 0x40 → … → 0x01 for vin=0x00.
- Busy/back-to-back: `start` pulses in cycles 10 and 29 → ignored. With `start` held high from cycle 0 → second `busy` rises in cycle 31, second `done` in cycle 59.
- Abort: finish a conversion with vin=0xA5, then start one with vin=0x3C and assert `abort` in its cycle 10 → IDLE next cycle, `busy`=0, `sample_en`=0, `dac_code`=0, no `done`, `result` stays 0xA5. A new `start` then yields `result`=0x3C.
- Metastability/sync: toggle `cmp_in` asynchronously off-edge during SETTLE only, and hold it stable for ≥2 cycles before each DECIDE → result matches the model. Verify that `cmp_in` changes in the final cycle before DECIDE do not affect that bit.
